// File: rtl/whack_pkg.sv
// Shared encodings for the whack-a-mole game: phase codes, scheduler states, LFSR taps.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package whack_pkg;

    // Game-phase codes from the timing controller; 2'b11 is treated as game over.
    localparam logic [1:0] PHASE_COUNTDOWN = 2'b00;
    localparam logic [1:0] PHASE_RUN       = 2'b01;
    localparam logic [1:0] PHASE_OVER      = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SPAWN = 2'b01,
        UP    = 2'b10,
        COOL  = 2'b11
    } state_t;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit free-running Fibonacci LFSR used to pick the next mole.
// Latency: new value every clock; output is the register itself.
// Backpressure: none, always advances. Ports: clk, rst_n, lfsr_o.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Raises one pseudo-random mole at a time during the running phase, detects whacks, scores hits.
// Latency: whack rise or expiry tick in cycle n shows on hit/miss/mole_up in cycle n+1.
// Backpressure: none; tick paces the game. Optional MOLE_SPEEDUP_EN shortens up time every 4th hit.
// Ports: clk, reset (async active-low), tick, game_phase, whack -> mole_up, hit, miss, score.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int          NUM_MOLES  = 4,
    parameter int          UP_TICKS   = 8,
    parameter int          COOL_TICKS = 2,
    parameter int          SCORE_W    = 8,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [1:0]           game_phase,
    input  logic [NUM_MOLES-1:0] whack,
    output logic [NUM_MOLES-1:0] mole_up,
    output logic                 hit,
    output logic                 miss,
    output logic [SCORE_W-1:0]   score
);

    localparam int TMAX    = (UP_TICKS > COOL_TICKS) ? UP_TICKS : COOL_TICKS;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam logic [TIMER_W-1:0]   UP_LOAD   = TIMER_W'(UP_TICKS);
    localparam logic [TIMER_W-1:0]   COOL_LOAD = TIMER_W'(COOL_TICKS);
    localparam logic [TIMER_W-1:0]   T_ONE     = TIMER_W'(1);
    localparam logic [2:0]           LAST_IDX  = 3'(NUM_MOLES - 1);
    localparam logic [NUM_MOLES-1:0] ONE_MOLE  = NUM_MOLES'(1);

    state_t                 state_q, state_d;
    logic [NUM_MOLES-1:0]   mole_q, mole_d;
    logic [NUM_MOLES-1:0]   whack_q;
    logic [NUM_MOLES-1:0]   rise;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [2:0]             last_q, last_d;
    logic [2:0]             idx;
    logic [7:0]             lfsr;
    logic [7:0]             lfsr_mod;
    logic [TIMER_W-1:0]     reload;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (reset),
        .lfsr_o (lfsr)
    );

    assign rise     = whack & ~whack_q;
    assign lfsr_mod = 8'(lfsr % NUM_MOLES);

`ifdef MOLE_SPEEDUP_EN
    logic [TIMER_W-1:0] up_len_q;
    logic [1:0]         hit_cnt_q;

    assign reload = up_len_q;

    // Every fourth hit shortens the up window by one tick, never below 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_len_q  <= UP_LOAD;
            hit_cnt_q <= 2'd0;
        end else if (game_phase == PHASE_COUNTDOWN) begin
            up_len_q  <= UP_LOAD;
            hit_cnt_q <= 2'd0;
        end else if (hit_d) begin
            hit_cnt_q <= hit_cnt_q + 2'd1;
            if (hit_cnt_q == 2'd3 && up_len_q > TIMER_W'(2)) begin
                up_len_q <= up_len_q - T_ONE;
            end
        end
    end
`else
    assign reload = UP_LOAD;
`endif

    always_comb begin
        state_d = state_q;
        mole_d  = mole_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        score_d = score_q;
        timer_d = timer_q;
        last_d  = last_q;
        idx     = lfsr_mod[2:0];
        // Never repeat the previous mole back to back.
        if (idx == last_q) begin
            idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end

        if (game_phase != PHASE_RUN) begin
            // Leaving the running phase drops the mole; score survives unless counting down.
            state_d = IDLE;
            mole_d  = '0;
            if (state_q == IDLE && game_phase == PHASE_COUNTDOWN) begin
                score_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    mole_d  = '0;
                    state_d = SPAWN;
                end
                SPAWN: begin
                    mole_d  = ONE_MOLE << idx;
                    last_d  = idx;
                    timer_d = reload;
                    state_d = UP;
                end
                UP: begin
                    // A hit outranks a simultaneous expiry tick.
                    if ((rise & mole_q) != '0) begin
                        hit_d   = 1'b1;
                        if (score_q != '1) begin
                            score_d = score_q + 1'b1;
                        end
                        mole_d  = '0;
                        timer_d = COOL_LOAD;
                        state_d = COOL;
                    end else if (tick) begin
                        if (timer_q == T_ONE) begin
                            miss_d  = 1'b1;
                            mole_d  = '0;
                            timer_d = COOL_LOAD;
                            state_d = COOL;
                        end else begin
                            timer_d = timer_q - T_ONE;
                        end
                    end
                end
                COOL: begin
                    mole_d = '0;
                    if (tick) begin
                        if (timer_q == T_ONE) begin
                            state_d = SPAWN;
                        end else begin
                            timer_d = timer_q - T_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mole_q  <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
            timer_q <= '0;
            last_q  <= 3'd0;
            whack_q <= '0;
        end else begin
            state_q <= state_d;
            mole_q  <= mole_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            whack_q <= whack;
        end
    end

    assign mole_up = mole_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign score   = score_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: spawn/expiry, hit, wrong whack, hit-vs-expiry,
// phase exit, score saturation and clear, async reset, up-time reload (MOLE_SPEEDUP_EN aware).
module tb_mole_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [1:0] game_phase;
    logic [3:0] whack;
    logic [3:0] mole_up;
    logic       hit;
    logic       miss;
    logic [7:0] score;

    int vectors     = 0;
    int miscompares = 0;
    int exp_score   = 0;

    mole_scheduler #(
        .NUM_MOLES (4),
        .UP_TICKS  (8),
        .COOL_TICKS(2),
        .SCORE_W   (8),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .game_phase (game_phase),
        .whack      (whack),
        .mole_up    (mole_up),
        .hit        (hit),
        .miss       (miss),
        .score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mole();
        int n;
        n = 0;
        while (mole_up == 4'b0 && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_mole_up", {31'b0, |mole_up}, 32'd1);
    endtask

    task automatic hit_once();
        tick = 1'b1;
        wait_mole();
        whack = mole_up;
        cyc();
        exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        chk("hit_once_hit", {31'b0, hit}, 32'd1);
        chk("hit_once_score", {24'b0, score}, exp_score);
        whack = 4'b0;
        tick  = 1'b0;
    endtask

    // Bounce through game over back into running: a fresh mole is up at the end.
    task automatic restart();
        tick       = 1'b0;
        game_phase = 2'b10;
        cyc();
        game_phase = 2'b01;
        cyc();
        cyc();
        chk("restart_onehot", {31'b0, $onehot(mole_up)}, 32'd1);
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] other;
        int         nhits;
        int         cnt;
        int         exp_up;

        reset      = 1'b1;
        tick       = 1'b0;
        game_phase = 2'b00;
        whack      = 4'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mole_up", {28'b0, mole_up}, 32'd0);
        chk("reset_hit", {31'b0, hit}, 32'd0);
        chk("reset_miss", {31'b0, miss}, 32'd0);
        chk("reset_score", {24'b0, score}, 32'd0);
        cyc();
        cyc();
        reset      = 1'b1;
        game_phase = 2'b01;

        // First mole within two clocks, then expiry after the 8th tick.
        cyc();
        cyc();
        chk("first_mole_onehot", {31'b0, $onehot(mole_up)}, 32'd1);
        prev = mole_up;
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i < 7) begin
                chk("up_no_miss", {31'b0, miss}, 32'd0);
                chk("up_mole_held", {28'b0, mole_up}, {28'b0, prev});
                cyc();
            end
        end
        chk("expiry_miss", {31'b0, miss}, 32'd1);
        chk("expiry_mole_down", {28'b0, mole_up}, 32'd0);
        chk("expiry_no_hit", {31'b0, hit}, 32'd0);
        cyc();
        chk("miss_one_cycle", {31'b0, miss}, 32'd0);
        tick = 1'b1;
        cyc();
        chk("cool_mole_down", {28'b0, mole_up}, 32'd0);
        cyc();
        tick = 1'b0;
        cyc();
        chk("second_mole_onehot", {31'b0, $onehot(mole_up)}, 32'd1);
        chk("second_mole_differs", {31'b0, mole_up != prev}, 32'd1);

        // Correct whack, then held button must not re-score.
        whack = mole_up;
        cyc();
        exp_score = 1;
        chk("hit_pulse", {31'b0, hit}, 32'd1);
        chk("hit_no_miss", {31'b0, miss}, 32'd0);
        chk("hit_score", {24'b0, score}, exp_score);
        chk("hit_mole_down", {28'b0, mole_up}, 32'd0);
        nhits = 0;
        tick  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (hit) nhits++;
        end
        tick  = 1'b0;
        whack = 4'b0;
        chk("held_no_rehit", nhits, 32'd0);
        chk("held_score", {24'b0, score}, exp_score);

        // Whack on a different mole is ignored.
        restart();
        prev  = mole_up;
        other = {prev[2:0], prev[3]};
        whack = other;
        cyc();
        chk("wrong_no_hit", {31'b0, hit}, 32'd0);
        chk("wrong_no_miss", {31'b0, miss}, 32'd0);
        chk("wrong_score", {24'b0, score}, exp_score);
        chk("wrong_mole_kept", {28'b0, mole_up}, {28'b0, prev});
        whack = 4'b0;
        cyc();

        // Whack lands on the expiring tick: hit wins.
        for (int i = 0; i < 7; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        chk("pre_expiry_mole_kept", {28'b0, mole_up}, {28'b0, prev});
        tick  = 1'b1;
        whack = mole_up;
        cyc();
        exp_score = 2;
        chk("race_hit", {31'b0, hit}, 32'd1);
        chk("race_no_miss", {31'b0, miss}, 32'd0);
        chk("race_score", {24'b0, score}, exp_score);
        tick  = 1'b0;
        whack = 4'b0;
        cyc();

        // Game over mid-UP drops the mole, keeps score.
        restart();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick       = 1'b0;
        game_phase = 2'b10;
        cyc();
        chk("over_mole_down", {28'b0, mole_up}, 32'd0);
        chk("over_no_hit", {31'b0, hit}, 32'd0);
        chk("over_no_miss", {31'b0, miss}, 32'd0);
        chk("over_score_hold", {24'b0, score}, exp_score);
        cyc();
        cyc();
        chk("over_score_hold_later", {24'b0, score}, exp_score);

        // Drive score to the ceiling, then one more hit must saturate.
        game_phase = 2'b01;
        for (int i = 0; i < 253; i++) begin
            hit_once();
        end
        chk("score_at_max", {24'b0, score}, 32'd255);
        hit_once();
        chk("score_saturated", {24'b0, score}, 32'd255);

        // Countdown clears the score.
        game_phase = 2'b00;
        cyc();
        cyc();
        exp_score = 0;
        chk("countdown_clear", {24'b0, score}, 32'd0);
        chk("countdown_mole_down", {28'b0, mole_up}, 32'd0);

        // Asynchronous reset mid-UP clears outputs without a clock edge.
        game_phase = 2'b01;
        hit_once();
        tick = 1'b1;
        wait_mole();
        tick = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_mole_up", {28'b0, mole_up}, 32'd0);
        chk("async_score", {24'b0, score}, 32'd0);
        chk("async_hit", {31'b0, hit}, 32'd0);
        chk("async_miss", {31'b0, miss}, 32'd0);
        cyc();
        reset      = 1'b1;
        exp_score  = 0;
        game_phase = 2'b00;
        cyc();
        game_phase = 2'b01;

        // Up window after 8 hits: shortened to 6 with speedup, otherwise unchanged.
        for (int i = 0; i < 8; i++) begin
            hit_once();
        end
        tick = 1'b1;
        wait_mole();
        cnt = 0;
        while (!miss && cnt < 20) begin
            cyc();
            cnt++;
        end
        tick = 1'b0;
`ifdef MOLE_SPEEDUP_EN
        exp_up = 6;
`else
        exp_up = 8;
`endif
        chk("up_time_after_8_hits", cnt, exp_up);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences the moles during the running phase of a game, based on the game-phase code from the game timing controller.
- Picks a pseudo-random mole, holds it up for a bounded number of ticks, and detects whacks.
- Emits hit/miss pulses and keeps a saturating score for the display path.
- Sits between the phase controller, the debounced button bank and the LED/score outputs.

Parameters:
- NUM_MOLES, 4, number of moles/buttons; 2..8.
- UP_TICKS, 8, ticks a mole stays up; >=2.
- COOL_TICKS, 2, ticks with all moles down between moles; >=1.
- SCORE_W, 8, score width.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle timing enable (game timebase)
- game_phase  in  2  00 countdown, 01 running, 10 game over, 11 treated as game over
- whack  in  NUM_MOLES  debounced buttons, synchronous to clk, level
- mole_up  out  NUM_MOLES  one-hot raised mole, or all zero
- hit  out  1  one-cycle pulse, correct whack
- miss  out  1  one-cycle pulse, mole expired un-whacked
- score  out  SCORE_W  hit count

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, reset). All outputs registered.
- Reset (reset=0), takes effect immediately:
  - state=IDLE, mole_up=0, hit=0, miss=0, score=0.
  - lfsr=LFSR_SEED, timer=0, last_idx=0, whack_q=0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clk, independent of state.
- Edge detect: whack_q <= whack every clk; rise = whack & ~whack_q.
- IDLE:
  - mole_up=0.
  - game_phase==00: score cleared to 0.
  - game_phase==01: next state SPAWN.
- SPAWN (one cycle):
  - idx = lfsr mod NUM_MOLES; if idx==last_idx, idx=(idx+1) mod NUM_MOLES.
  - mole_up<=onehot(idx), last_idx<=idx, timer<=UP_TICKS, next state UP.
- UP:
  - rise on the raised mole: hit<=1 next cycle, score+1 (saturates at all-ones), mole_up<=0, timer<=COOL_TICKS, next state COOL.
  - rise on any other mole is ignored; no penalty.
  - tick with timer==1 and no hit: miss<=1, mole_up<=0, timer<=COOL_TICKS, next state COOL.
  - otherwise, tick decrements timer.
  - hit and expiry in the same cycle: hit wins, no miss.
- COOL:
  - mole_up=0; tick decrements timer.
  - tick with timer==1: next state SPAWN.
- Phase exit: in any state, game_phase!=01 sends the block to IDLE next cycle.
  - mole_up<=0; no hit/miss in that cycle.
  - score holds, and is cleared only in phase 00.
- Latency:
  - whack rising at input in cycle n gives hit=1 and mole_up=0 in cycle n+1.
  - Expiry tick in cycle n gives miss and mole_up=0 in cycle n+1.
- hit and miss are never high together; mole_up is always one-hot or zero.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined:
  - Reload value up_len starts at UP_TICKS.
  - Every 4th hit decrements up_len by 1, with a floor of 2.
  - up_len resets to UP_TICKS on reset and while game_phase==00.
  - SPAWN loads timer<=up_len.
- Undefined: timer always loads UP_TICKS; no up_len register exists.

Decomposition:
- Package whack_pkg holds:
  - phase encodings: PHASE_COUNTDOWN=2'b00, PHASE_RUN=2'b01, PHASE_OVER=2'b10.
  - state encoding: IDLE, SPAWN, UP, COOL.
  - LFSR tap constant.
- One sub-module: mole_lfsr (8-bit free-running LFSR, seed parameter, async active-low reset).

Test Plan:
- Reset then phase=01 → mole_up one-hot within 2 clk. With no whack and 8 ticks, miss=1 for exactly 1 cycle after the 8th tick and mole_up=0. Then 2 ticks later a new mole is up, different from the previous one.
- Mole k up, whack[k] rises → hit=1 next cycle, score 0→1, mole_up=0. Holding whack[k] for 20 cycles gives no second hit.
- Mole k up, whack[j≠k] rises → no hit, no miss, score unchanged, mole k still up.
- Whack rise on the cycle of the expiring tick → hit=1, miss=0, score+1.
- score preset to 255 (SCORE_W=8) plus one more hit → score stays 255. phase→10 mid-UP → mole_up=0 next cycle and score holds. phase→00 → score=0.
- reset asserted mid-UP → outputs zero immediately. With MOLE_SPEEDUP_EN, 8 hits → up time is 6 ticks.
